snn_frame_scheduler: RTL
========================

// Module: snn_frame_scheduler
// PURPOSE
//  Frame-level controller for snn_network_array. Accepts a pixel stream over valid/ready.
//  Clears the array, presents one pixel per step and pulses the per-neuron enables.
//  Waits for each enabled neuron's data_valid, accumulates per-neuron spike counts over
//  the frame, then resolves the winning neuron (argmax) and returns it over valid/ready.
// PARAMETERS
//  DATA_WIDTH    8    pixel width; matches snn_network_array
//  NUM_NEURONS   10   neurons in the array
//  FRAME_PIXELS  784  pixels per frame (>=1)
//  CNT_WIDTH     10   per-neuron spike counter width
//  MAX_WAIT      64   max cycles to wait for valid flags per pixel
//  IDX_W = $clog2(NUM_NEURONS) (localparam)
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            synchronous active-low reset
//  start        in   1            begin frame (sampled in IDLE only)
//  neuron_mask  in   NUM_NEURONS  participating neurons, latched at start
//  pix_valid    in   1            pixel available
//  pix_data     in   DATA_WIDTH   pixel value
//  pix_ready    out  1            scheduler accepts pixel
//  net_rst_n    out  1            sync active-low clear to array
//  net_pixel    out  DATA_WIDTH   pixel to array pixel_in
//  net_enables  out  NUM_NEURONS  to array enables_in
//  net_fired    in   NUM_NEURONS  from array fired_flags_out
//  net_valid    in   NUM_NEURONS  from array valid_flags_out
//  class_valid  out  1            result available
//  class_ready  in   1            result consumed
//  class_idx    out  IDX_W        winning neuron
//  class_count  out  CNT_WIDTH    winner's spike count
//  no_spike     out  1            no enabled neuron spiked / mask empty
//  timeout_err  out  1            frame aborted on MAX_WAIT expiry
//  busy         out  1            state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (net_rst_n=0 while rst_n low); state IDLE; counters/mask cleared.
//  Mid-frame reset: back to IDLE on that edge; no pixel accepted; result discarded.
//  FSM: IDLE->CLEAR->FEED<->WAIT->ARGMAX->DONE->IDLE.
//  IDLE: start=1 latches mask.
//    - mask==0 -> DONE directly: no_spike=1, class_idx=0; no pixels consumed.
//    - otherwise -> CLEAR.
//  CLEAR: exactly 1 cycle net_rst_n=0, spike counts and pixel counter zeroed -> FEED.
//  FEED: pix_ready=1. On pix_valid&pix_ready, register pix_data into net_pixel
//    (held until next accept) and drive net_enables=mask for exactly the next cycle -> WAIT.
//  WAIT: pix_ready=0, net_enables=0 except the pulse cycle.
//    - vseen|=net_valid&mask; fseen|=net_fired&net_valid&mask, both cleared on entry.
//    - When vseen==mask: count[i]+=fseen[i], saturating at 2^CNT_WIDTH-1.
//      Last pixel (FRAME_PIXELS-1) -> ARGMAX, else FEED.
//    - Min accept-to-accept spacing: 3 cycles.
//    - Wait counter > MAX_WAIT -> DONE with timeout_err=1, class_idx=0, class_count=0.
//  ARGMAX: scan i=0..NUM_NEURONS-1, one per cycle (NUM_NEURONS cycles).
//    - Update best only if mask[i] && count[i]>best (strict: lowest index wins ties).
//    - best==0 after scan -> no_spike=1, class_idx=lowest masked index.
//  DONE: class_valid=1; class_idx/count/no_spike/timeout_err stable until class_ready.
//    - Transfer on class_valid&class_ready -> IDLE; flags clear on transfer.
//    - start ignored while busy.
//  net_rst_n=1 in every state except CLEAR and reset.
// TESTING
//  T1 N=4,FRAME=3,mask=4'b1111; array fires neuron2 every pixel, others never
//     -> class_idx=2, count=3, no_spike=0.
//  T2 tie: neurons1,3 each fire 2/3 pixels -> class_idx=1, class_count=2.
//  T3 CNT_WIDTH=2,FRAME=5, neuron0 fires every pixel -> class_count=3 (saturated).
//  T4 net_valid of neuron3 never rises, MAX_WAIT=8 -> timeout_err=1 after 9 wait cycles, idx=0.
//  T5 mask=0 + start -> class_valid next-next cycle, no_spike=1, pix_ready never 1.
//  T6 rst_n low during WAIT of pixel 2, class_ready held 0 in DONE
//     -> IDLE, busy=0; next frame counts from zero; result held until ready.

Source files
------------

// File: rtl/snn_frame_scheduler.sv
// Frame-level sequencer for snn_network_array: streams pixels into the array one step at a time,
// accumulates per-neuron spike counts over a frame and returns the argmax neuron over valid/ready.
module snn_frame_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_NEURONS  = 10,
    parameter int FRAME_PIXELS = 784,
    parameter int CNT_WIDTH    = 10,
    parameter int MAX_WAIT     = 64,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] neuron_mask,
    input  logic                   pix_valid,
    input  logic [DATA_WIDTH-1:0]  pix_data,
    output logic                   pix_ready,
    output logic                   net_rst_n,
    output logic [DATA_WIDTH-1:0]  net_pixel,
    output logic [NUM_NEURONS-1:0] net_enables,
    input  logic [NUM_NEURONS-1:0] net_fired,
    input  logic [NUM_NEURONS-1:0] net_valid,
    output logic                   class_valid,
    input  logic                   class_ready,
    output logic [IDX_W-1:0]       class_idx,
    output logic [CNT_WIDTH-1:0]   class_count,
    output logic                   no_spike,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int PIX_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_NEURONS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] mask_q, mask_d;
    logic [NUM_NEURONS-1:0] vseen_q, vseen_d;
    logic [NUM_NEURONS-1:0] fseen_q, fseen_d;
    logic                   en_pulse_q, en_pulse_d;
    logic [DATA_WIDTH-1:0]  pixel_q, pixel_d;
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0]      wait_next;
    logic [CNT_WIDTH-1:0]   count_q   [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]   count_d   [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]   count_inc [NUM_NEURONS];
    logic [IDX_W-1:0]       scan_q, scan_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic [CNT_WIDTH-1:0]   best_q, best_d;
    logic [IDX_W-1:0]       res_idx_q, res_idx_d;
    logic [CNT_WIDTH-1:0]   res_cnt_q, res_cnt_d;
    logic                   no_spike_q, no_spike_d;
    logic                   timeout_q, timeout_d;
    logic [IDX_W-1:0]       first_masked;

    // Saturating per-neuron increment, applied only when a pixel step completes.
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
        assign count_inc[gi] = (fseen_q[gi] && (count_q[gi] != '1)) ? count_q[gi] + 1'b1
                                                                     : count_q[gi];
    end

    always_comb begin
        first_masked = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_masked = IDX_W'(i);
            end
        end
    end

    assign wait_next = wait_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        vseen_d    = vseen_q;
        fseen_d    = fseen_q;
        en_pulse_d = 1'b0;
        pixel_d    = pixel_q;
        pix_cnt_d  = pix_cnt_q;
        wait_cnt_d = wait_cnt_q;
        count_d    = count_q;
        scan_d     = scan_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        res_idx_d  = res_idx_q;
        res_cnt_d  = res_cnt_q;
        no_spike_d = no_spike_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d = neuron_mask;
                    if (neuron_mask == '0) begin
                        state_d    = S_DONE;
                        res_idx_d  = '0;
                        res_cnt_d  = '0;
                        no_spike_d = 1'b1;
                        timeout_d  = 1'b0;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end

            S_CLEAR: begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    count_d[i] = '0;
                end
                pix_cnt_d = '0;
                state_d   = S_FEED;
            end

            S_FEED: begin
                if (pix_valid) begin
                    pixel_d    = pix_data;
                    en_pulse_d = 1'b1;
                    vseen_d    = '0;
                    fseen_d    = '0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                vseen_d    = vseen_q | (net_valid & mask_q);
                fseen_d    = fseen_q | (net_fired & net_valid & mask_q);
                wait_cnt_d = wait_next;
                // Completion wins over timeout when both land on the same cycle.
                if (vseen_q == mask_q) begin
                    count_d   = count_inc;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d    = S_ARGMAX;
                        scan_d     = '0;
                        best_d     = '0;
                        best_idx_d = '0;
                    end else begin
                        state_d = S_FEED;
                    end
                end else if (wait_next > WAIT_LIMIT) begin
                    state_d    = S_DONE;
                    timeout_d  = 1'b1;
                    no_spike_d = 1'b0;
                    res_idx_d  = '0;
                    res_cnt_d  = '0;
                end
            end

            S_ARGMAX: begin
                if (mask_q[scan_q] && (count_q[scan_q] > best_q)) begin
                    best_d     = count_q[scan_q];
                    best_idx_d = scan_q;
                end
                scan_d = scan_q + 1'b1;
                if (scan_q == LAST_IDX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                    if (best_d == '0) begin
                        no_spike_d = 1'b1;
                        res_idx_d  = first_masked;
                        res_cnt_d  = '0;
                    end else begin
                        no_spike_d = 1'b0;
                        res_idx_d  = best_idx_d;
                        res_cnt_d  = best_d;
                    end
                end
            end

            S_DONE: begin
                if (class_ready) begin
                    state_d    = S_IDLE;
                    res_idx_d  = '0;
                    res_cnt_d  = '0;
                    no_spike_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            vseen_q    <= '0;
            fseen_q    <= '0;
            en_pulse_q <= 1'b0;
            pixel_q    <= '0;
            pix_cnt_q  <= '0;
            wait_cnt_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                count_q[i] <= '0;
            end
            scan_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            res_idx_q  <= '0;
            res_cnt_q  <= '0;
            no_spike_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            vseen_q    <= vseen_d;
            fseen_q    <= fseen_d;
            en_pulse_q <= en_pulse_d;
            pixel_q    <= pixel_d;
            pix_cnt_q  <= pix_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            count_q    <= count_d;
            scan_q     <= scan_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            res_idx_q  <= res_idx_d;
            res_cnt_q  <= res_cnt_d;
            no_spike_q <= no_spike_d;
            timeout_q  <= timeout_d;
        end
    end

    // The array clear follows rst_n directly so it is low for the whole reset, not just after an edge.
    assign net_rst_n   = rst_n && (state_q != S_CLEAR);
    assign pix_ready   = (state_q == S_FEED);
    assign net_pixel   = pixel_q;
    assign net_enables = en_pulse_q ? mask_q : '0;
    assign class_valid = (state_q == S_DONE);
    assign class_idx   = res_idx_q;
    assign class_count = res_cnt_q;
    assign no_spike    = no_spike_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE);

endmodule
